// File: rtl/sumador_6b_pkg.sv
// Shared constants for the sumador_6b registered adder.
//   SUM_WIDTH : default operand/result width in bits
package sumador_6b_pkg;

    localparam int unsigned SUM_WIDTH = 6;

endpackage : sumador_6b_pkg

// File: rtl/sumador_1b.sv
// Combinational 1-bit full adder, one stage of the ripple chain.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module sumador_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term shared by sum and carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : sumador_1b

// File: rtl/sumador_6b.sv
// Registered ripple-carry adder Y = A + B + Cin with carry, overflow and zero flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : sample A, B, Cin this cycle
//   A, B, Cin  : operands and carry-in
//   Y, Cout    : registered sum and carry-out
//   ovf, zero  : registered signed-overflow and zero flags
//   out_valid  : outputs were updated at the last edge
module sumador_6b
    import sumador_6b_pkg::*;
#(
    parameter int unsigned WIDTH = SUM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf_comb;
    logic             zero_comb;

    logic [WIDTH-1:0] y_d, y_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    // Ripple chain: carry of stage i feeds stage i+1.
    assign c[0] = Cin;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
        sumador_1b u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Signed overflow: carry into and out of the sign bit disagree.
    assign ovf_comb  = c[WIDTH] ^ c[WIDTH-1];
    assign zero_comb = ~|s;

    // Capture on valid, otherwise hold results and drop the valid strobe.
    always_comb begin
        y_d         = y_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            y_d         = s;
            cout_d      = c[WIDTH];
            ovf_d       = ovf_comb;
            zero_d      = zero_comb;
            out_valid_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Y         = y_q;
    assign Cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule : sumador_6b

// File: tb/tb_sumador_6b.sv
// Self-checking bench for sumador_6b: directed vector table, hand-written
// reset/hold/back-to-back sequences, and random stimulus against an
// arithmetic reference model.
module tb_sumador_6b;

    localparam int unsigned W = 6;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         out_valid;

    int n_tests;
    int n_fail;

    // Expected output state kept by the bench.
    logic [W-1:0] e_y;
    logic         e_cout, e_ovf, e_zero, e_valid;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] y;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs[8];

    sumador_6b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a_in),
        .B         (b_in),
        .Cin       (cin),
        .Y         (y),
        .Cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference: plain integer arithmetic, unsigned and signed views.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int sum_u, sa, sb, sum_s;
        sum_u = int'(a) + int'(b) + int'(ci);
        sa    = (int'(a) >= 32) ? int'(a) - 64 : int'(a);
        sb    = (int'(b) >= 32) ? int'(b) - 64 : int'(b);
        sum_s = sa + sb + int'(ci);
        e_y    = W'(sum_u % 64);
        e_cout = (sum_u >= 64);
        e_ovf  = (sum_s > 31) || (sum_s < -32);
        e_zero = ((sum_u % 64) == 0);
    endtask

    task automatic check(input string name, input logic [W-1:0] ey, input logic ec,
                         input logic eo, input logic ez, input logic ev);
        n_tests++;
        if (y !== ey || cout !== ec || ovf !== eo || zero !== ez || out_valid !== ev) begin
            n_fail++;
            $display("FAIL %s: got Y=%0d Cout=%b ovf=%b zero=%b out_valid=%b, want Y=%0d Cout=%b ovf=%b zero=%b out_valid=%b",
                     name, y, cout, ovf, zero, out_valid, ey, ec, eo, ez, ev);
        end
    endtask

    // Drive one operation at the falling edge, check one cycle later.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] ey, input logic ec,
                         input logic eo, input logic ez);
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        cin      = ci;
        @(posedge clk);
        #1;
        check(name, ey, ec, eo, ez, 1'b1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        cin      = 1'b0;
        rst_n    = 1'b1;

        //         a       b       cin    y       cout  ovf   zero
        vecs[0] = '{6'd0,  6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b1};
        vecs[1] = '{6'd54, 6'd0,  1'b0, 6'd54, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{6'd54, 6'd12, 1'b0, 6'd2,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{6'd63, 6'd0,  1'b1, 6'd0,  1'b1, 1'b0, 1'b1};
        vecs[4] = '{6'd31, 6'd1,  1'b0, 6'd32, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{6'd32, 6'd32, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1};
        vecs[6] = '{6'd63, 6'd63, 1'b1, 6'd63, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{6'd31, 6'd31, 1'b1, 6'd63, 1'b0, 1'b1, 1'b0};

        // Power-on reset, asserted between edges.
        #1 rst_n = 1'b0;
        #2;
        check("reset_initial", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, applied back-to-back (in_valid stays high).
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].y, vecs[i].cout, vecs[i].ovf, vecs[i].zero);
        end

        // Hold: result of the last vector stays, valid drops.
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = 6'd5;
        b_in     = 6'd7;
        @(posedge clk);
        #1;
        check("hold", 6'd63, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("hold2", 6'd63, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation: pending result discarded, nothing replayed.
        do_op("pre_reset", 6'd54, 6'd0, 1'b0, 6'd54, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 6'd10;
        b_in     = 6'd20;
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("no_replay", '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // First capture right after release.
        do_op("post_reset", 6'd1, 6'd2, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0);

        // Random stimulus against the reference model.
        e_y = 6'd4; e_cout = 1'b0; e_ovf = 1'b0; e_zero = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            a_in     = W'($urandom_range(0, 63));
            b_in     = W'($urandom_range(0, 63));
            cin      = 1'($urandom_range(0, 1));
            if (in_valid) model(a_in, b_in, cin);
            e_valid = in_valid;
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", i), e_y, e_cout, e_ovf, e_zero, e_valid);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sumador_6b
